// File: rtl/hazard_sched.sv
// Hazard controller and execute-stage scheduler: operand forwarding,
// load-use / PC-write stalls and flushes, and multi-cycle op sequencing.
module hazard_sched #(
    parameter int MUL_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] RA1D_i,
    input  logic [3:0] RA2D_i,
    input  logic [3:0] RA1E_i,
    input  logic [3:0] RA2E_i,
    input  logic [3:0] WA3E_i,
    input  logic [3:0] WA3M_i,
    input  logic [3:0] WA3W_i,
    input  logic       RegWriteE_i,
    input  logic       RegWriteM_i,
    input  logic       RegWriteW_i,
    input  logic       MemtoRegE_i,
    input  logic       PCSrcD_i,
    input  logic       PCSrcE_i,
    input  logic       PCSrcM_i,
    input  logic       PCSrcW_i,
    input  logic       BranchTakenE_i,
    input  logic       MulStartE_i,
    output logic [1:0] ForwardAE_o,
    output logic [1:0] ForwardBE_o,
    output logic       StallF_o,
    output logic       StallD_o,
    output logic       StallE_o,
    output logic       FlushD_o,
    output logic       FlushE_o,
    output logic       BubbleM_o,
    output logic       MulDoneE_o,
    output logic       Busy_o
);

    localparam int CW = $clog2(MUL_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_INIT =
        CW'((MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mul_stall;
    logic            mul_done;
    logic            ldr_stall;
    logic            pc_pend;

    function automatic logic [1:0] fwd_sel(
        input logic [3:0] ra,
        input logic       rw_m,
        input logic [3:0] wa_m,
        input logic       rw_w,
        input logic [3:0] wa_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        // R15 reads the PC path, never a forwarded result
        if (ra != 4'd15) begin
            if (rw_m && (wa_m == ra)) begin
                sel = 2'b10;
            end else if (rw_w && (wa_w == ra)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_stall = 1'b0;
        mul_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MulStartE_i) begin
                    if (MUL_CYCLES == 1) begin
                        mul_done = 1'b1;
                    end else begin
                        mul_stall = 1'b1;
                        state_d   = BUSY;
                        cnt_d     = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    mul_stall = 1'b1;
                    cnt_d     = cnt_q - CW'(1);
                end else begin
                    mul_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ldr_stall = MemtoRegE_i & RegWriteE_i &
                       ((WA3E_i == RA1D_i) | (WA3E_i == RA2D_i));
    assign pc_pend   = PCSrcD_i | PCSrcE_i | PCSrcM_i;

    always_comb begin
        ForwardAE_o = 2'b00;
        ForwardBE_o = 2'b00;
        StallF_o    = 1'b0;
        StallD_o    = 1'b0;
        StallE_o    = 1'b0;
        FlushD_o    = 1'b0;
        FlushE_o    = 1'b0;
        BubbleM_o   = 1'b0;
        MulDoneE_o  = 1'b0;
        Busy_o      = 1'b0;
        if (!reset_i) begin
            ForwardAE_o = fwd_sel(RA1E_i, RegWriteM_i, WA3M_i,
                                  RegWriteW_i, WA3W_i);
            ForwardBE_o = fwd_sel(RA2E_i, RegWriteM_i, WA3M_i,
                                  RegWriteW_i, WA3W_i);
            StallF_o    = ldr_stall | pc_pend | mul_stall;
            StallD_o    = ldr_stall | mul_stall;
            StallE_o    = mul_stall;
            BubbleM_o   = mul_stall;
            MulDoneE_o  = mul_done;
            Busy_o      = (state_q == BUSY);
            // the held op in E must survive any redirect
            if (!mul_stall) begin
                FlushD_o = pc_pend | PCSrcW_i | BranchTakenE_i;
                FlushE_o = ldr_stall | BranchTakenE_i;
            end
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: a behavioural model pushes expected
// outputs per cycle; a monitor on the falling edge pops and compares.
module tb_hazard_sched;

    typedef struct packed {
        logic       rst;
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       rwe, rwm, rww, m2r;
        logic       pcd, pce, pcm, pcw, bt, ms;
    } stim_t;

    typedef struct packed {
        logic [11:0] e4;
        logic [11:0] e1;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE;

    logic [1:0] fa4, fb4, fa1, fb1;
    logic       sf4, sd4, se4, fd4, fe4, bm4, dn4, by4;
    logic       sf1, sd1, se1, fd1, fe1, bm1, dn1, by1;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   age4   = -1;
    int   age1   = -1;
    int   cyc    = 0;

    always #5 clk = ~clk;

    hazard_sched #(.MUL_CYCLES(4)) u_dut4 (
        .clk_i(clk), .reset_i(reset),
        .RA1D_i(RA1D), .RA2D_i(RA2D), .RA1E_i(RA1E), .RA2E_i(RA2E),
        .WA3E_i(WA3E), .WA3M_i(WA3M), .WA3W_i(WA3W),
        .RegWriteE_i(RegWriteE), .RegWriteM_i(RegWriteM),
        .RegWriteW_i(RegWriteW), .MemtoRegE_i(MemtoRegE),
        .PCSrcD_i(PCSrcD), .PCSrcE_i(PCSrcE), .PCSrcM_i(PCSrcM),
        .PCSrcW_i(PCSrcW), .BranchTakenE_i(BranchTakenE),
        .MulStartE_i(MulStartE),
        .ForwardAE_o(fa4), .ForwardBE_o(fb4),
        .StallF_o(sf4), .StallD_o(sd4), .StallE_o(se4),
        .FlushD_o(fd4), .FlushE_o(fe4), .BubbleM_o(bm4),
        .MulDoneE_o(dn4), .Busy_o(by4)
    );

    hazard_sched #(.MUL_CYCLES(1)) u_dut1 (
        .clk_i(clk), .reset_i(reset),
        .RA1D_i(RA1D), .RA2D_i(RA2D), .RA1E_i(RA1E), .RA2E_i(RA2E),
        .WA3E_i(WA3E), .WA3M_i(WA3M), .WA3W_i(WA3W),
        .RegWriteE_i(RegWriteE), .RegWriteM_i(RegWriteM),
        .RegWriteW_i(RegWriteW), .MemtoRegE_i(MemtoRegE),
        .PCSrcD_i(PCSrcD), .PCSrcE_i(PCSrcE), .PCSrcM_i(PCSrcM),
        .PCSrcW_i(PCSrcW), .BranchTakenE_i(BranchTakenE),
        .MulStartE_i(MulStartE),
        .ForwardAE_o(fa1), .ForwardBE_o(fb1),
        .StallF_o(sf1), .StallD_o(sd1), .StallE_o(se1),
        .FlushD_o(fd1), .FlushE_o(fe1), .BubbleM_o(bm1),
        .MulDoneE_o(dn1), .Busy_o(by1)
    );

    function automatic logic [1:0] fwd(input logic [3:0] ra, input stim_t s);
        if (ra == 4'd15) return 2'b00;
        if (s.rwm && s.wa3m == ra) return 2'b10;
        if (s.rww && s.wa3w == ra) return 2'b01;
        return 2'b00;
    endfunction

    // age: index of the current cycle within a multi-cycle op, -1 when idle
    function automatic logic [11:0] model(input stim_t s, input int m,
                                          input int age, output int age_n);
        int   idx;
        logic busy, mstall, done, ldr, pcp, sF, sD, fD, fE;
        age_n = -1;
        if (s.rst) return 12'd0;
        busy   = (age >= 0);
        idx    = busy ? age : (s.ms ? 0 : -1);
        mstall = (idx >= 0) && (idx < m - 1);
        done   = (idx >= 0) && (idx == m - 1);
        age_n  = mstall ? idx + 1 : -1;
        ldr = s.m2r && s.rwe && (s.wa3e == s.ra1d || s.wa3e == s.ra2d);
        pcp = s.pcd || s.pce || s.pcm;
        sF  = ldr || pcp || mstall;
        sD  = ldr || mstall;
        fD  = !mstall && (pcp || s.pcw || s.bt);
        fE  = !mstall && (ldr || s.bt);
        return {fwd(s.ra1e, s), fwd(s.ra2e, s), sF, sD, mstall,
                fD, fE, mstall, done, busy};
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        int   n4, n1;
        reset = s.rst;
        RA1D = s.ra1d; RA2D = s.ra2d; RA1E = s.ra1e; RA2E = s.ra2e;
        WA3E = s.wa3e; WA3M = s.wa3m; WA3W = s.wa3w;
        RegWriteE = s.rwe; RegWriteM = s.rwm; RegWriteW = s.rww;
        MemtoRegE = s.m2r;
        PCSrcD = s.pcd; PCSrcE = s.pce; PCSrcM = s.pcm; PCSrcW = s.pcw;
        BranchTakenE = s.bt; MulStartE = s.ms;
        e.e4 = model(s, 4, age4, n4);
        e.e1 = model(s, 1, age1, n1);
        q.push_back(e);
        age4 = n4;
        age1 = n1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] raddr();
        if ($urandom_range(0, 7) == 0) return 4'd15;
        return 4'($urandom_range(0, 3));
    endfunction

    function automatic logic rbit(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [11:0] g4, g1;
        if (q.size() > 0) begin
            e  = q.pop_front();
            g4 = {fa4, fb4, sf4, sd4, se4, fd4, fe4, bm4, dn4, by4};
            g1 = {fa1, fb1, sf1, sd1, se1, fd1, fe1, bm1, dn1, by1};
            n_chk++;
            if (g4 === e.e4) n_pass++;
            else $display("FAIL mc4 cyc%0d got=%b exp=%b", cyc, g4, e.e4);
            n_chk++;
            if (g1 === e.e1) n_pass++;
            else $display("FAIL mc1 cyc%0d got=%b exp=%b", cyc, g1, e.e1);
            cyc++;
        end
    end

    initial begin
        stim_t s;
        stim_t z;
        z = '0;
        s = '0;
        s.rst = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(s);
        step(s);
        // forwarding priority
        s = z; s.rwm = 1; s.wa3m = 3; s.rww = 1; s.wa3w = 3; s.ra1e = 3;
        step(s);
        s.rwm = 0;
        step(s);
        s.rwm = 1; s.ra1e = 15; s.wa3m = 15; s.wa3w = 15;
        step(s);
        // load-use
        s = z; s.m2r = 1; s.rwe = 1; s.wa3e = 5; s.ra2d = 5; s.ra1d = 1;
        step(s);
        step(z);
        // PC write walking down the pipe
        s = z; s.pcd = 1; step(s);
        s = z; s.pce = 1; step(s);
        s = z; s.pcm = 1; step(s);
        s = z; s.pcw = 1; step(s);
        step(z);
        s = z; s.bt = 1; step(s);
        // back-to-back multi-cycle ops
        s = z; s.ms = 1;
        for (int i = 0; i < 8; i++) step(s);
        step(z);
        // reset mid-op
        s = z; s.ms = 1; step(s);
        s.rst = 1; step(s);
        for (int i = 0; i < 3; i++) step(z);
        // redirect while a multi-cycle op holds E
        s = z; s.ms = 1; step(s);
        s.bt = 1; s.pcw = 1; step(s);
        s.bt = 0; s.pcw = 0; step(s);
        step(s);
        step(z);
        for (int i = 0; i < 600; i++) begin
            s.rst  = rbit(3);
            s.ra1d = raddr(); s.ra2d = raddr();
            s.ra1e = raddr(); s.ra2e = raddr();
            s.wa3e = raddr(); s.wa3m = raddr(); s.wa3w = raddr();
            s.rwe = rbit(60); s.rwm = rbit(60); s.rww = rbit(60);
            s.m2r = rbit(30);
            s.pcd = rbit(8); s.pce = rbit(8); s.pcm = rbit(8);
            s.pcw = rbit(8); s.bt = rbit(10); s.ms = rbit(35);
            step(s);
        end
        step(z);
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain left=%0d required=0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
